beeper: RTL and testbench

Audio tone generator fed by the microcontroller's output ports. A toggle on a control port triggers a beep sequence, with parameters latched at the trigger. The block drives a square wave at a programmed half-period for a programmed duration, followed by a fixed silent gap. The sequence repeats up to 8 times, then a one-cycle done pulse is issued. It sits downstream of the datapath's `out1..out4` registers and drives the board buzzer pin.

---
 rtl/beeper_pkg.sv | 21 ++
 rtl/beeper_prescaler.sv | 44 ++++
 rtl/beeper.sv | 199 +++++++++++++++++++
 tb/tb_beeper.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/beeper_pkg.sv
// beeper_pkg: shared definitions for the beeper tone generator.
//   state_e            FSM state encoding (IDLE/PLAY/GAP)
//   DEF_*              default timing parameters for a production build
//   CTL_*              bit positions inside the ctl control byte
package beeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned DEF_TICK_DIV  = 1000;
  localparam int unsigned DEF_DUR_DIV   = 500000;
  localparam int unsigned DEF_GAP_UNITS = 5;

  localparam int unsigned CTL_TOG_BIT = 0;
  localparam int unsigned CTL_REP_LSB = 1;
  localparam int unsigned CTL_REP_MSB = 3;

endpackage

// File: rtl/beeper_prescaler.sv
// prescaler: divide-by-DIV counter with synchronous clear and enable.
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   clr_i    synchronous clear of the count (wins over enable)
//   en_i     count enable
//   tick_o   high for the one enabled cycle that completes each DIV-cycle period
module prescaler #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Tick deliberately ignores clr_i so the FSM can derive its clear from the
  // tick without forming a combinational loop.
  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/beeper.sv
// beeper: square-wave buzzer driver with repeat and silent gap.
//   clk    system clock
//   reset  asynchronous active-low reset
//   note   tone half-period in note ticks (0 = silent tone)
//   dur    beep length in duration units (0 = finish immediately)
//   ctl    bit0 trigger toggle, bits[3:1] extra repeats, bits[7:4] unused
//   audio  square-wave output (registered)
//   busy   high while a sequence runs (registered)
//   done   one-cycle pulse when a sequence completes (registered)
//
// state | meaning
// IDLE  | no sequence; audio low, waiting for a toggle on ctl[0]
// PLAY  | tone running for dur duration units
// GAP   | silent gap of GAP_UNITS duration units, then repeat or finish
module beeper
  import beeper_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned DUR_DIV   = DEF_DUR_DIV,
  parameter int unsigned GAP_UNITS = DEF_GAP_UNITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] note,
  input  logic [7:0] dur,
  input  logic [7:0] ctl,
  output logic       audio,
  output logic       busy,
  output logic       done
);

  localparam int unsigned GW = $clog2(GAP_UNITS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_UNITS - 1);

  state_e     state_q, state_d;
  logic       tog_q, tog_d;
  logic [7:0] note_q, note_d;
  logic [7:0] dur_q, dur_d;
  logic [2:0] rep_q, rep_d;
  logic [7:0] note_cnt_q, note_cnt_d;
  logic [7:0] dur_cnt_q, dur_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic       audio_q, audio_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic trig;
  logic restart;
  logic note_tick;
  logic dur_tick;
  logic note_clr;
  logic dur_clr;
  logic unused_ctl;

  assign unused_ctl = ^ctl[7:4];

  assign trig = ctl[CTL_TOG_BIT] ^ tog_q;

  // Prescalers restart on every trigger and state change so each phase
  // begins with a full tick period.
  assign note_clr = restart || (state_q != ST_PLAY);
  assign dur_clr  = restart || (state_q == ST_IDLE);

  prescaler #(.DIV(TICK_DIV)) u_note_pre (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (note_clr),
    .en_i   (state_q == ST_PLAY),
    .tick_o (note_tick)
  );

  prescaler #(.DIV(DUR_DIV)) u_dur_pre (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (dur_clr),
    .en_i   (state_q != ST_IDLE),
    .tick_o (dur_tick)
  );

  always_comb begin
    state_d    = state_q;
    tog_d      = ctl[CTL_TOG_BIT];
    note_d     = note_q;
    dur_d      = dur_q;
    rep_d      = rep_q;
    note_cnt_d = note_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    audio_d    = audio_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    restart    = 1'b0;

    if (trig) begin
      // A trigger wins in every state, including the final GAP cycle.
      restart    = 1'b1;
      note_d     = note;
      dur_d      = dur;
      rep_d      = ctl[CTL_REP_MSB:CTL_REP_LSB];
      note_cnt_d = '0;
      dur_cnt_d  = '0;
      gap_cnt_d  = '0;
      audio_d    = 1'b0;
      if (dur == 8'd0) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = ST_PLAY;
        busy_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          if (note_tick && (note_q != 8'd0)) begin
            if (note_cnt_q == note_q - 8'd1) begin
              note_cnt_d = '0;
              audio_d    = ~audio_q;
            end else begin
              note_cnt_d = note_cnt_q + 8'd1;
            end
          end
          // Placed after the tone logic so end-of-beep forces audio low.
          if (dur_tick) begin
            if (dur_cnt_q == dur_q - 8'd1) begin
              restart    = 1'b1;
              state_d    = ST_GAP;
              audio_d    = 1'b0;
              note_cnt_d = '0;
              dur_cnt_d  = '0;
              gap_cnt_d  = '0;
            end else begin
              dur_cnt_d = dur_cnt_q + 8'd1;
            end
          end
        end
        ST_GAP: begin
          audio_d = 1'b0;
          if (dur_tick) begin
            if (gap_cnt_q == GAP_LAST) begin
              restart    = 1'b1;
              gap_cnt_d  = '0;
              dur_cnt_d  = '0;
              note_cnt_d = '0;
              if (rep_q != 3'd0) begin
                rep_d   = rep_q - 3'd1;
                state_d = ST_PLAY;
              end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end else begin
              gap_cnt_d = gap_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          audio_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tog_q      <= 1'b0;
      note_q     <= '0;
      dur_q      <= '0;
      rep_q      <= '0;
      note_cnt_q <= '0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      audio_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tog_q      <= tog_d;
      note_q     <= note_d;
      dur_q      <= dur_d;
      rep_q      <= rep_d;
      note_cnt_q <= note_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      audio_q    <= audio_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign audio = audio_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_beeper.sv
// tb_beeper: directed bench for beeper with TICK_DIV=2, DUR_DIV=10, GAP_UNITS=1.
module tb_beeper;

  logic       clk;
  logic       reset;
  logic [7:0] note;
  logic [7:0] dur;
  logic [7:0] ctl;
  logic       audio;
  logic       busy;
  logic       done;

  int n_checks;
  int n_err;

  logic [127:0] aud_tr;
  logic [127:0] bsy_tr;
  logic [127:0] dn_tr;
  int bsy_n;
  int dn_n;
  int aud_n;
  int dn_at;

  beeper #(
    .TICK_DIV  (2),
    .DUR_DIV   (10),
    .GAP_UNITS (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .note  (note),
    .dur   (dur),
    .ctl   (ctl),
    .audio (audio),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample n cycles, each #1 after an active edge; index i = cycles since start.
  task automatic capture(input int n);
    aud_tr = '0;
    bsy_tr = '0;
    dn_tr  = '0;
    bsy_n  = 0;
    dn_n   = 0;
    aud_n  = 0;
    dn_at  = -1;
    for (int i = 0; i < n && i < 128; i++) begin
      step();
      aud_tr[i] = audio;
      bsy_tr[i] = busy;
      dn_tr[i]  = done;
      if (busy)  bsy_n++;
      if (audio) aud_n++;
      if (done) begin
        dn_n++;
        if (dn_at < 0) dn_at = i;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ctl   = 8'h00;
    note  = 8'h00;
    dur   = 8'h00;
    repeat (2) step();
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b0;
    note     = 8'h00;
    dur      = 8'h00;
    ctl      = 8'h00;
    #2;
    check_val("rst_audio", {31'd0, audio}, 32'd0);
    check_val("rst_busy",  {31'd0, busy},  32'd0);
    check_val("rst_done",  {31'd0, done},  32'd0);
    do_reset();
    step();
    check_val("idle_busy", {31'd0, busy}, 32'd0);

    // Basic beep: note=3, dur=2, no repeats.
    note = 8'd3; dur = 8'd2; ctl = 8'h01;
    capture(40);
    check_val("basic_busy_n",  bsy_n, 32'd30);
    check_val("basic_busy_tr", bsy_tr[31:0], 32'h3FFF_FFFF);
    check_val("basic_audio",   aud_tr[31:0], 32'h000C_0FC0);
    check_val("basic_done_n",  dn_n, 32'd1);
    check_val("basic_done_tr", dn_tr[31:0], 32'h4000_0000);

    // Repeats: ctl=0x07 gives three extra beeps.
    do_reset();
    note = 8'd1; dur = 8'd1; ctl = 8'h07;
    capture(90);
    check_val("rep_busy_n",  bsy_n, 32'd80);
    check_val("rep_busy_end", {31'd0, bsy_tr[80]}, 32'd0);
    check_val("rep_done_n",  dn_n, 32'd1);
    check_val("rep_done_at", dn_at, 32'd80);
    check_val("rep_aud_n",   aud_n, 32'd16);
    check_val("rep_aud_b0",  aud_tr[19:0], 32'h000CC);
    check_val("rep_aud_b3",  aud_tr[79:60], 32'h000CC);

    // dur=0: no busy, done on the first edge.
    do_reset();
    note = 8'd5; dur = 8'd0; ctl = 8'h01;
    capture(5);
    check_val("dur0_busy_n", bsy_n, 32'd0);
    check_val("dur0_done_n", dn_n, 32'd1);
    check_val("dur0_done_at", dn_at, 32'd0);

    // note=0: silent tone with normal timing.
    do_reset();
    note = 8'd0; dur = 8'd1; ctl = 8'h01;
    capture(25);
    check_val("note0_busy_n", bsy_n, 32'd20);
    check_val("note0_aud_n",  aud_n, 32'd0);
    check_val("note0_done_at", dn_at, 32'd20);

    // Retrigger 7 cycles into PLAY with note=1.
    do_reset();
    note = 8'd3; dur = 8'd2; ctl = 8'h01;
    capture(7);
    check_val("retrig_pre_audio", {31'd0, aud_tr[6]}, 32'd1);
    check_val("retrig_pre_done",  dn_n, 32'd0);
    note = 8'd1; ctl = 8'h00;
    capture(40);
    check_val("retrig_busy_n", bsy_n, 32'd30);
    check_val("retrig_audio",  aud_tr[31:0], 32'h000C_CCCC);
    check_val("retrig_done_n", dn_n, 32'd1);
    check_val("retrig_done_at", dn_at, 32'd30);

    // Trigger on the final GAP cycle wins over completion.
    do_reset();
    note = 8'd1; dur = 8'd1; ctl = 8'h01;
    capture(20);
    check_val("edge_first_busy", bsy_n, 32'd20);
    ctl = 8'h00;
    capture(25);
    check_val("edge_no_done_0", {31'd0, dn_tr[0]}, 32'd0);
    check_val("edge_busy_n",   bsy_n, 32'd20);
    check_val("edge_done_n",   dn_n, 32'd1);
    check_val("edge_done_at",  dn_at, 32'd20);

    // Reset mid-PLAY, then release with ctl[0]=1.
    do_reset();
    note = 8'd1; dur = 8'd2; ctl = 8'h01;
    capture(3);
    check_val("mid_pre_audio", {31'd0, audio}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_val("mid_rst_audio", {31'd0, audio}, 32'd0);
    check_val("mid_rst_busy",  {31'd0, busy},  32'd0);
    check_val("mid_rst_done",  {31'd0, done},  32'd0);
    step();
    check_val("mid_rst_hold_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    capture(40);
    check_val("post_rst_busy0",  {31'd0, bsy_tr[0]}, 32'd1);
    check_val("post_rst_busy_n", bsy_n, 32'd30);
    check_val("post_rst_audio",  aud_tr[31:0], 32'h000C_CCCC);
    check_val("post_rst_done_at", dn_at, 32'd30);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
